// File: rtl/prio_arbiter_4.sv
// Four-requester arbiter with a registered one-hot grant, encoded index and hold timeout.
// Define ROUND_ROBIN_EN for rotating priority; otherwise fixed priority 3>2>1>0.
module prio_arbiter_4 #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] MAX_HOLD_C = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_t           state_reg, state_next;
    logic [3:0]       gnt_reg, gnt_next;
    logic [1:0]       gnt_id_reg, gnt_id_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             timeout_reg, timeout_next;
    logic [1:0]       win_id;

`ifdef ROUND_ROBIN_EN
    logic [1:0] ptr_reg, ptr_next;
    logic [3:0] rot_req;
    logic [1:0] win_offset;

    // rot_req[gi] is the request gi steps below the pointer, so bit 0 is the current favourite.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_rot
            assign rot_req[gi] = req[ptr_reg - 2'(gi)];
        end
    endgenerate

    always_comb begin
        win_offset = 2'd3;
        if (rot_req[0])      win_offset = 2'd0;
        else if (rot_req[1]) win_offset = 2'd1;
        else if (rot_req[2]) win_offset = 2'd2;
        win_id = ptr_reg - win_offset;
    end
`else
    always_comb begin
        win_id = 2'd0;
        if (req[3])      win_id = 2'd3;
        else if (req[2]) win_id = 2'd2;
        else if (req[1]) win_id = 2'd1;
    end
`endif

    always_comb begin
        state_next   = state_reg;
        gnt_next     = gnt_reg;
        gnt_id_next  = gnt_id_reg;
        cnt_next     = cnt_reg;
        timeout_next = 1'b0;
`ifdef ROUND_ROBIN_EN
        ptr_next     = ptr_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (|req) begin
                    state_next  = BUSY;
                    gnt_next    = 4'b0001 << win_id;
                    gnt_id_next = win_id;
                    cnt_next    = CNT_ONE;
                end
            end
            BUSY: begin
                if (!req[gnt_id_reg] || (MAX_HOLD != 0 && cnt_reg == MAX_HOLD_C)) begin
                    state_next   = IDLE;
                    gnt_next     = 4'b0000;
                    gnt_id_next  = 2'd0;
                    cnt_next     = '0;
                    // A release by the owner takes precedence over the timeout pulse.
                    timeout_next = req[gnt_id_reg];
`ifdef ROUND_ROBIN_EN
                    ptr_next     = gnt_id_reg - 2'd1;
`endif
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            default: begin
                state_next  = IDLE;
                gnt_next    = 4'b0000;
                gnt_id_next = 2'd0;
                cnt_next    = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            gnt_reg     <= 4'b0000;
            gnt_id_reg  <= 2'd0;
            cnt_reg     <= '0;
            timeout_reg <= 1'b0;
`ifdef ROUND_ROBIN_EN
            ptr_reg     <= 2'd3;
`endif
        end else begin
            state_reg   <= state_next;
            gnt_reg     <= gnt_next;
            gnt_id_reg  <= gnt_id_next;
            cnt_reg     <= cnt_next;
            timeout_reg <= timeout_next;
`ifdef ROUND_ROBIN_EN
            ptr_reg     <= ptr_next;
`endif
        end
    end

    assign gnt     = gnt_reg;
    assign gnt_id  = gnt_id_reg;
    assign busy    = (state_reg == BUSY);
    assign timeout = timeout_reg;

endmodule

// File: tb/tb_prio_arbiter_4.sv
// Directed bench for prio_arbiter_4; builds with or without ROUND_ROBIN_EN.
module tb_prio_arbiter_4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       busy;
    logic       timeout;

    int checks = 0;
    int errors = 0;
    bit inv_on = 1'b0;

    prio_arbiter_4 #(.MAX_HOLD(8), .CNT_W(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .busy    (busy),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    // Advance one edge; outputs are then sampled 1 time unit later.
    task automatic tick(input string tag);
        @(posedge clk);
        #1;
        $display("[%0t] %s rst_n=%b req=%b gnt=%b gnt_id=%0d busy=%b timeout=%b",
                 $time, tag, rst_n, req, gnt, gnt_id, busy, timeout);
    endtask

    // Invariants on every falling edge once reset has been applied.
    always @(negedge clk) begin
        if (inv_on) begin
            checks++;
            if ($countones(gnt) > 1 || busy !== (|gnt) ||
                (busy && gnt !== (4'b0001 << gnt_id)) || (!busy && gnt_id !== 2'd0)) begin
                errors++;
                $display("FAIL invariant: gnt=%b gnt_id=%0d busy=%b", gnt, gnt_id, busy);
            end
        end
    end

    task automatic test_reset;
        rst_n = 1'b0;
        req   = 4'b1111;
        for (int i = 0; i < 2; i++) begin
            tick("reset");
            inv_on = 1'b1;
            checks++;
            if (gnt !== 4'b0000 || gnt_id !== 2'd0 || busy !== 1'b0 || timeout !== 1'b0) begin
                errors++;
                $display("FAIL reset: gnt=%b gnt_id=%0d busy=%b timeout=%b, want 0000/0/0/0",
                         gnt, gnt_id, busy, timeout);
            end
        end
        rst_n = 1'b1;
        req   = 4'b0000;
        tick("idle");
    endtask

    task automatic test_priority;
        req = 4'b0110;
        tick("prio grant");
        checks++;
        if (gnt !== 4'b0100 || gnt_id !== 2'd2 || busy !== 1'b1) begin
            errors++;
            $display("FAIL prio_first: gnt=%b gnt_id=%0d busy=%b, want 0100/2/1", gnt, gnt_id, busy);
        end
        req = 4'b0010;
        tick("prio release");
        checks++;
        if (gnt !== 4'b0000 || busy !== 1'b0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL prio_turnaround: gnt=%b busy=%b timeout=%b, want 0000/0/0", gnt, busy, timeout);
        end
        tick("prio regrant");
        checks++;
        if (gnt !== 4'b0010 || gnt_id !== 2'd1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL prio_second: gnt=%b gnt_id=%0d busy=%b, want 0010/1/1", gnt, gnt_id, busy);
        end
        req = 4'b0000;
        tick("prio drop");
        checks++;
        if (busy !== 1'b0 || gnt !== 4'b0000) begin
            errors++;
            $display("FAIL prio_idle: gnt=%b busy=%b, want 0000/0", gnt, busy);
        end
    endtask

    task automatic test_timeout;
        req = 4'b0001;
        tick("to grant");
        checks++;
        if (gnt !== 4'b0001 || gnt_id !== 2'd0 || busy !== 1'b1 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL to_grant: gnt=%b gnt_id=%0d busy=%b timeout=%b, want 0001/0/1/0",
                     gnt, gnt_id, busy, timeout);
        end
        for (int i = 2; i <= 8; i++) begin
            tick("to hold");
            checks++;
            if (busy !== 1'b1 || gnt !== 4'b0001 || timeout !== 1'b0) begin
                errors++;
                $display("FAIL to_hold cycle %0d: gnt=%b busy=%b timeout=%b, want 0001/1/0",
                         i, gnt, busy, timeout);
            end
        end
        tick("to release");
        checks++;
        if (busy !== 1'b0 || gnt !== 4'b0000 || timeout !== 1'b1) begin
            errors++;
            $display("FAIL to_release: gnt=%b busy=%b timeout=%b, want 0000/0/1", gnt, busy, timeout);
        end
        tick("to regrant");
        checks++;
        if (gnt !== 4'b0001 || busy !== 1'b1 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL to_regrant: gnt=%b busy=%b timeout=%b, want 0001/1/0", gnt, busy, timeout);
        end
        req = 4'b0000;
        tick("to drop");
        checks++;
        if (busy !== 1'b0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL to_drop: busy=%b timeout=%b, want 0/0", busy, timeout);
        end
    endtask

    task automatic test_reset_mid_grant;
        req = 4'b1000;
        tick("rst grant");
        tick("rst hold");
        checks++;
        if (gnt !== 4'b1000 || gnt_id !== 2'd3 || busy !== 1'b1) begin
            errors++;
            $display("FAIL rst_hold: gnt=%b gnt_id=%0d busy=%b, want 1000/3/1", gnt, gnt_id, busy);
        end
        rst_n = 1'b0;
        tick("rst assert");
        checks++;
        if (gnt !== 4'b0000 || gnt_id !== 2'd0 || busy !== 1'b0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid: gnt=%b gnt_id=%0d busy=%b timeout=%b, want 0000/0/0/0",
                     gnt, gnt_id, busy, timeout);
        end
        rst_n = 1'b1;
        tick("rst regrant");
        checks++;
        if (gnt !== 4'b1000 || gnt_id !== 2'd3 || busy !== 1'b1) begin
            errors++;
            $display("FAIL rst_regrant: gnt=%b gnt_id=%0d busy=%b, want 1000/3/1", gnt, gnt_id, busy);
        end
        req = 4'b0000;
        tick("rst drop");
    endtask

    task automatic test_back_to_back;
        logic [1:0] exp_id [5];
`ifdef ROUND_ROBIN_EN
        exp_id = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd3};
`else
        exp_id = '{2'd3, 2'd3, 2'd3, 2'd3, 2'd3};
`endif
        // Fresh reset so the pointer starts at 3.
        rst_n = 1'b0;
        tick("b2b reset");
        rst_n = 1'b1;
        req   = 4'b1111;
        for (int r = 0; r < 5; r++) begin
            tick("b2b grant");
            checks++;
            if (busy !== 1'b1 || gnt_id !== exp_id[r] || gnt !== (4'b0001 << exp_id[r])) begin
                errors++;
                $display("FAIL b2b_grant round %0d: gnt=%b gnt_id=%0d busy=%b, want id %0d",
                         r, gnt, gnt_id, busy, exp_id[r]);
            end
            tick("b2b hold");
            req = 4'b1111 & ~(4'b0001 << exp_id[r]);
            tick("b2b release");
            checks++;
            if (busy !== 1'b0 || gnt !== 4'b0000 || timeout !== 1'b0) begin
                errors++;
                $display("FAIL b2b_release round %0d: gnt=%b busy=%b timeout=%b, want 0000/0/0",
                         r, gnt, busy, timeout);
            end
            req = 4'b1111;
        end
        req = 4'b0000;
        tick("b2b idle");
    endtask

    task automatic test_same_edge;
        req = 4'b0010;
        tick("se grant");
        checks++;
        if (gnt !== 4'b0010 || gnt_id !== 2'd1) begin
            errors++;
            $display("FAIL se_grant: gnt=%b gnt_id=%0d, want 0010/1", gnt, gnt_id);
        end
        tick("se hold");
        req = 4'b1000;
        tick("se release");
        checks++;
        if (busy !== 1'b0 || gnt !== 4'b0000) begin
            errors++;
            $display("FAIL se_release: gnt=%b busy=%b, want 0000/0", gnt, busy);
        end
        tick("se regrant");
        checks++;
        if (gnt !== 4'b1000 || gnt_id !== 2'd3 || busy !== 1'b1) begin
            errors++;
            $display("FAIL se_regrant: gnt=%b gnt_id=%0d busy=%b, want 1000/3/1", gnt, gnt_id, busy);
        end
        req = 4'b0000;
        tick("se drop");
        tick("se idle");
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 4'b0000;
        test_reset();
        test_priority();
        test_timeout();
        test_reset_mid_grant();
        test_back_to_back();
        test_same_edge();
        inv_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
